ecc_fault_inject_ram: RTL and testbench
=======================================

Name: ecc_fault_inject_ram

Overview:
- Simple dual-port RAM of 80-bit words with 14-bit read and write addresses; write side has 10-bit lane enables.
- Read path adds single-bit fault injection on the 64-bit data field (bits 63:0).
- A SEC-DED Hamming(72,64) stage detects and corrects the injected fault, then reports error status, faulty address and faulty data.
- Used as an ECC/fault-injection demonstrator on PolarFire LSRAM.

Parameters:
- ADDR_W, 14, address width of R_ADDR/W_ADDR.
- DEPTH, 16384, number of words (2**ADDR_W).
- WORD_W, 80, stored word width.
- DATA_W, 64, protected data field width (word bits 63:0).
- LANES, 8, number of write-enable lanes; lane width = WORD_W/LANES = 10.

Ports:
- CLK  in  1  rising-edge clock for everything.
- RST  in  1  reset, synchronous, active-high.
- W_EN  in  1  write strobe.
- W_ADDR  in  14  write address.
- W_DATA  in  80  write data.
- WBYTE_EN  in  8  lane enables; bit i covers word bits [10i+9:10i].
- R_EN  in  1  read strobe.
- R_ADDR  in  14  read address.
- selectt  in  64  fault-injection bit index, sampled with the read; value <64 flips that data bit, any other value (including X/Z) means no injection.
- R_DATA  out  80  raw word read.
- data_64_out  out  64  corrected data.
- ERRr  out  1  error detected on the current result.
- error_flag  out  1  sticky error indicator.
- error_address  out  14  address of the last erroneous read.
- error_data  out  64  uncorrected (faulted) data of the last erroneous read.

Behaviour:
- Write: on a CLK edge with W_EN=1, for each i with WBYTE_EN[i]=1, mem[W_ADDR][10i+9:10i] <= W_DATA lane i. Other lanes keep their value. Memory is not cleared by RST.
- Read stage 1: on a CLK edge with R_EN=1:
  - R_DATA <= mem[R_ADDR]; one-cycle latency.
  - R_ADDR and selectt are captured into a pipeline register with valid=1.
  - With R_EN=0, R_DATA holds and valid=0.
- Read and write to the same address in the same cycle: read returns the old data (read-first).
- Stage 2, computed from the stage-1 registers:
  - d = R_DATA[63:0]; chk = encode(d), giving 7 Hamming bits plus overall parity.
  - d' = d with bit selectt flipped when selectt<64, else d' = d.
  - syn = encode(d') xor chk.
  - syn==0: no error.
  - Overall-parity mismatch with syn nonzero: single error; flip the indicated bit of d'.
  - Hamming bits nonzero with parity matched: double error; detect only, no correction.
- Stage 2 register update, on a CLK edge with stage-1 valid=1 (two cycles after R_EN sampled):
  - data_64_out <= corrected data, or d' when uncorrectable.
  - ERRr <= (syn != 0).
  - If syn != 0: error_address <= captured address, error_data <= d', error_flag <= 1.
- When valid=0, all stage-2 outputs hold.
- error_flag is cleared only by RST.
- RST=1 at a clock edge clears: R_DATA, data_64_out, ERRr, error_flag, error_address, error_data, and the pipeline valid bits. A read in flight at reset is discarded.
- Writes during RST are ignored.

Decomposition:
- Shared package: DATA_W, WORD_W, LANE_W, ECC_W=8, the Hamming(72,64) parity-check masks, and an encode function.
- One sub-module, secded64_dec: inputs d', chk; outputs corrected data, single_err, double_err. Purely combinational.

Test Plan:
- Write addr 1..11 with data 11..19, 77, and the pattern word, all WBYTE_EN=8'hFF. Read addr 1 with selectt=100 → R_DATA=11 after 1 cycle; data_64_out=11, ERRr=0, error_flag=0 after 2 cycles.
- Read addr 2 with selectt=0 → data_64_out=12, ERRr=1, error_flag=1, error_address=2, error_data=13.
- Back-to-back reads, one per cycle:
  - addr 3 with selectt=1 → error_data=15, data_64_out=13.
  - addr 10 with selectt=63 → error_data=77 xor 2^63, data_64_out=77.
  - addr 5 with selectt=100 → ERRr=0; error_address stays 10 and error_flag stays 1.
- Partial write: addr 33 holds 33, then write W_DATA=80'h3FF to addr 33 with WBYTE_EN=8'h01 → read returns R_DATA=0x3FF, upper lanes unchanged.
- Same-cycle write 99 and read of addr 4 (holding 14) → R_DATA=14; the next read of addr 4 returns 99.
- After error_flag=1, assert RST for one cycle → all outputs read 0; memory content at addr 1 is still 11.

Source files
------------

// File: rtl/ecc_fault_inject_ram_pkg.sv
// Shared widths, Hamming(72,64) position table, parity-check masks and the
// SEC-DED check-bit encoder for the fault-injection RAM.
package ecc_fault_inject_ram_pkg;

  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned WORD_W     = 80;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned LANES      = 8;
  localparam int unsigned LANE_W     = WORD_W / LANES;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);
  localparam int unsigned ECC_W      = 8;
  localparam int unsigned HAM_W      = ECC_W - 1;
  localparam int unsigned SEL_W      = $clog2(DATA_W);
  localparam int unsigned CODE_LEN   = 72;

  typedef logic [DATA_W-1:0][HAM_W-1:0] pos_tab_t;
  typedef logic [HAM_W-1:0][DATA_W-1:0] mask_tab_t;

  // Codeword position of each data bit: positions 1..71 that are not powers of two
  function automatic pos_tab_t build_pos();
    pos_tab_t    tab;
    int unsigned idx;
    tab = '0;
    idx = 0;
    for (int unsigned p = 1; p < CODE_LEN; p++) begin
      if ((p & (p - 1)) != 0) begin
        tab[SEL_W'(idx)] = HAM_W'(p);
        idx++;
      end
    end
    return tab;
  endfunction

  localparam pos_tab_t DATA_POS = build_pos();

  function automatic mask_tab_t build_masks();
    mask_tab_t m;
    m = '0;
    for (int unsigned k = 0; k < HAM_W; k++) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        m[3'(k)][SEL_W'(i)] = DATA_POS[SEL_W'(i)][3'(k)];
      end
    end
    return m;
  endfunction

  localparam mask_tab_t H_MASK = build_masks();

  // Bits 6:0 are Hamming checks; bit 7 makes the 72-bit codeword even parity
  function automatic logic [ECC_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [ECC_W-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < HAM_W; k++) begin
      c[3'(k)] = ^(d & H_MASK[3'(k)]);
    end
    c[ECC_W-1] = ^{d, c[HAM_W-1:0]};
    return c;
  endfunction

endpackage

// File: rtl/ecc_fault_inject_ram_secded64_dec.sv
// Combinational SEC-DED Hamming(72,64) decoder: corrects single errors,
// flags double errors without correction.
module secded64_dec
  import ecc_fault_inject_ram_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic [ECC_W-1:0]  chk,
  output logic [DATA_W-1:0] data_out,
  output logic              single_err,
  output logic              double_err
);

  logic [ECC_W-1:0] enc;
  logic [HAM_W-1:0] syn_h;
  logic             p_err;

  always_comb begin
    enc        = encode(data_in);
    syn_h      = enc[HAM_W-1:0] ^ chk[HAM_W-1:0];
    p_err      = ^{data_in, chk};
    single_err = p_err;
    double_err = !p_err && (syn_h != '0);
    // A zero Hamming syndrome with a parity error is the overall-parity bit itself
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_out[SEL_W'(i)] = data_in[SEL_W'(i)]
                          ^ (p_err && (syn_h == DATA_POS[SEL_W'(i)]));
    end
  end

endmodule

// File: rtl/ecc_fault_inject_ram.sv
// Dual-port 80-bit RAM with lane-enabled writes, single-bit fault injection on
// the read data field and a SEC-DED correction/reporting stage.
module ecc_fault_inject_ram
  import ecc_fault_inject_ram_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                W_EN,
  input  logic [ADDR_W-1:0]   W_ADDR,
  input  logic [WORD_W-1:0]   W_DATA,
  input  logic [LANES-1:0]    WBYTE_EN,
  input  logic                R_EN,
  input  logic [ADDR_W-1:0]   R_ADDR,
  input  logic [63:0]         selectt,
  output logic [WORD_W-1:0]   R_DATA,
  output logic [DATA_W-1:0]   data_64_out,
  output logic                ERRr,
  output logic                error_flag,
  output logic [ADDR_W-1:0]   error_address,
  output logic [DATA_W-1:0]   error_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              inj_q;
  logic [SEL_W-1:0]  inj_idx_q;

  logic [DATA_W-1:0] d_inj;
  logic [ECC_W-1:0]  chk;
  logic [DATA_W-1:0] dec_data;
  logic              single_err;
  logic              double_err;
  logic              err;

  // Lane-masked write port; memory contents survive reset
  always_ff @(posedge CLK) begin
    if (!RST && W_EN) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (WBYTE_EN[LANE_IDX_W'(i)]) begin
          mem[W_ADDR][i*LANE_W +: LANE_W] <= W_DATA[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read stage 1: read-first word fetch plus capture of address and injection request
  always_ff @(posedge CLK) begin
    if (RST) begin
      R_DATA   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= R_EN;
      if (R_EN) begin
        R_DATA    <= mem[R_ADDR];
        rd_addr_q <= R_ADDR;
        inj_idx_q <= selectt[SEL_W-1:0];
        // Unknown select falls to the else branch: no injection
        if (selectt < 64'(DATA_W)) begin
          inj_q <= 1'b1;
        end else begin
          inj_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    chk   = encode(R_DATA[DATA_W-1:0]);
    d_inj = R_DATA[DATA_W-1:0];
    if (inj_q) begin
      d_inj[inj_idx_q] = ~d_inj[inj_idx_q];
    end
    err = single_err || double_err;
  end

  secded64_dec u_dec (
    .data_in    (d_inj),
    .chk        (chk),
    .data_out   (dec_data),
    .single_err (single_err),
    .double_err (double_err)
  );

  // Stage 2: result and sticky error reporting
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_64_out   <= '0;
      ERRr          <= 1'b0;
      error_flag    <= 1'b0;
      error_address <= '0;
      error_data    <= '0;
    end else if (rd_valid) begin
      data_64_out <= dec_data;
      ERRr        <= err;
      if (err) begin
        error_flag    <= 1'b1;
        error_address <= rd_addr_q;
        error_data    <= d_inj;
      end
    end
  end

endmodule

// File: tb/tb_ecc_fault_inject_ram.sv
// Scoreboard bench for ecc_fault_inject_ram: directed reads push expected
// responses, a negedge monitor pops and compares them.
module tb_ecc_fault_inject_ram;

  localparam logic [79:0] PATTERN   = 80'hA5A5_0123_4567_89AB_CDEF;
  localparam logic [79:0] PAT_LANE7 = 80'hFFE5_0123_4567_89AB_CDEF;
  localparam int unsigned DRAIN_MAX = 20;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic        flag;
    logic [13:0] eaddr;
    logic [63:0] edata;
  } s2_exp_t;

  logic        CLK;
  logic        RST;
  logic        W_EN;
  logic [13:0] W_ADDR;
  logic [79:0] W_DATA;
  logic [7:0]  WBYTE_EN;
  logic        R_EN;
  logic [13:0] R_ADDR;
  logic [63:0] selectt;
  logic [79:0] R_DATA;
  logic [63:0] data_64_out;
  logic        ERRr;
  logic        error_flag;
  logic [13:0] error_address;
  logic [63:0] error_data;

  int n_checks;
  int n_errors;

  logic [79:0] exp_r [$];
  s2_exp_t     exp_s [$];
  logic        m_flag;
  logic [13:0] m_eaddr;
  logic [63:0] m_edata;
  logic        en_d1;
  logic        en_d2;

  ecc_fault_inject_ram dut (
    .CLK           (CLK),
    .RST           (RST),
    .W_EN          (W_EN),
    .W_ADDR        (W_ADDR),
    .W_DATA        (W_DATA),
    .WBYTE_EN      (WBYTE_EN),
    .R_EN          (R_EN),
    .R_ADDR        (R_ADDR),
    .selectt       (selectt),
    .R_DATA        (R_DATA),
    .data_64_out   (data_64_out),
    .ERRr          (ERRr),
    .error_flag    (error_flag),
    .error_address (error_address),
    .error_data    (error_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bench-side timing of when each read's results become visible
  always @(posedge CLK) begin
    en_d1 <= RST ? 1'b0 : R_EN;
    en_d2 <= RST ? 1'b0 : en_d1;
  end

  always @(negedge CLK) begin
    s2_exp_t e;
    if (en_d1) begin
      if (exp_r.size() == 0) begin
        check("r_data_underflow", 80'd1, 80'd0);
      end else begin
        check("r_data", R_DATA, exp_r.pop_front());
      end
    end
    if (en_d2) begin
      if (exp_s.size() == 0) begin
        check("stage2_underflow", 80'd1, 80'd0);
      end else begin
        e = exp_s.pop_front();
        check("data_64_out", 80'(data_64_out), 80'(e.data));
        check("errr", 80'(ERRr), 80'(e.err));
        check("error_flag", 80'(error_flag), 80'(e.flag));
        check("error_address", 80'(error_address), 80'(e.eaddr));
        check("error_data", 80'(error_data), 80'(e.edata));
      end
    end
  end

  // One clock of stimulus; a read pushes its hand-supplied expected word and model status
  task automatic cyc(input logic we, input logic [13:0] wa, input logic [79:0] wd,
                     input logic [7:0] be, input logic re, input logic [13:0] ra,
                     input logic [63:0] sel, input logic [79:0] exp_word);
    s2_exp_t e;
    W_EN = we; W_ADDR = wa; W_DATA = wd; WBYTE_EN = be;
    R_EN = re; R_ADDR = ra; selectt = sel;
    if (re) begin
      exp_r.push_back(exp_word);
      if (sel < 64'd64) begin
        m_flag  = 1'b1;
        m_eaddr = ra;
        m_edata = exp_word[63:0] ^ (64'd1 << sel);
      end
      e.data  = exp_word[63:0];
      e.err   = (sel < 64'd64);
      e.flag  = m_flag;
      e.eaddr = m_eaddr;
      e.edata = m_edata;
      exp_s.push_back(e);
    end
    @(posedge CLK);
    #1;
    W_EN = 1'b0; R_EN = 1'b0; WBYTE_EN = '0; selectt = 64'd100;
  endtask

  task automatic wr(input logic [13:0] a, input logic [79:0] d, input logic [7:0] be);
    cyc(1'b1, a, d, be, 1'b0, '0, 64'd100, '0);
  endtask

  task automatic rd(input logic [13:0] a, input logic [63:0] sel, input logic [79:0] exp_word);
    cyc(1'b0, '0, '0, '0, 1'b1, a, sel, exp_word);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0, 64'd100, '0);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((exp_r.size() != 0 || exp_s.size() != 0) && cnt < DRAIN_MAX) begin
      @(posedge CLK);
      cnt++;
    end
    check("drain_pending", 80'(exp_r.size() + exp_s.size()), 80'd0);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_flag = 1'b0; m_eaddr = '0; m_edata = '0;
    RST = 1'b1; W_EN = 1'b0; W_ADDR = '0; W_DATA = '0; WBYTE_EN = '0;
    R_EN = 1'b0; R_ADDR = '0; selectt = 64'd100;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_r_data", R_DATA, 80'd0);
    check("rst_error_flag", 80'(error_flag), 80'd0);
    @(posedge CLK);
    #1;

    for (int a = 1; a <= 9; a++) wr(14'(a), 80'(a + 10), 8'hFF);
    wr(14'd10, 80'd77, 8'hFF);
    wr(14'd11, PATTERN, 8'hFF);
    wr(14'd33, 80'd33, 8'hFF);
    wr(14'd34, PATTERN, 8'hFF);
    idle(1);

    rd(14'd1, 64'd100, 80'd11);
    idle(2);
    rd(14'd2, 64'd0, 80'd12);
    idle(2);
    rd(14'd3, 64'd1, 80'd13);
    rd(14'd10, 64'd63, 80'd77);
    rd(14'd5, 64'd100, 80'd15);
    idle(2);
    rd(14'd11, 64'd40, PATTERN);
    rd(14'd6, 64'h0000_0001_0000_0000, 80'd16);

    wr(14'd33, 80'h3FF, 8'h01);
    rd(14'd33, 64'd100, 80'h3FF);
    wr(14'd34, {80{1'b1}}, 8'h80);
    rd(14'd34, 64'd7, PAT_LANE7);

    cyc(1'b1, 14'd4, 80'd99, 8'hFF, 1'b1, 14'd4, 64'd100, 80'd14);
    rd(14'd4, 64'd100, 80'd99);
    drain();

    check("pre_rst_flag", 80'(error_flag), 80'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_flag = 1'b0; m_eaddr = '0; m_edata = '0;
    @(negedge CLK);
    check("rst2_r_data", R_DATA, 80'd0);
    check("rst2_data_64_out", 80'(data_64_out), 80'd0);
    check("rst2_errr", 80'(ERRr), 80'd0);
    check("rst2_error_flag", 80'(error_flag), 80'd0);
    check("rst2_error_address", 80'(error_address), 80'd0);
    check("rst2_error_data", 80'(error_data), 80'd0);
    @(posedge CLK);
    #1;
    rd(14'd1, 64'd100, 80'd11);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
